// File: rtl/pwm_bank_pkg.sv
// Shared register map, control-field layout and bus helpers for the pwm_bank peripheral.
package pwm_bank_pkg;

  localparam logic [1:0]  CTRL        = 2'd0;
  localparam logic [1:0]  PERIOD      = 2'd1;
  localparam logic [1:0]  DUTY        = 2'd2;
  localparam logic [1:0]  COUNT       = 2'd3;
  localparam logic [11:0] SYNC_OFFSET = 12'h800;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_POL_BIT    = 1;
  localparam int unsigned CTRL_CENTER_BIT = 2;

  typedef struct packed {
    logic center;
    logic pol;
    logic en;
  } pwm_ctrl_t;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: edge/centre counter, active period/duty registers and registered output.
module pwm_bank_channel
  import pwm_bank_pkg::*;
#(
  parameter int unsigned CtrWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  pwm_ctrl_t           ctrl,
  input  logic [CtrWidth-1:0] period,
  input  logic [CtrWidth-1:0] duty,
  input  logic                sync,
  input  logic                restart,
  output logic [CtrWidth-1:0] cnt,
  output logic                pwm
);

  logic [CtrWidth-1:0] per_q;
  logic [CtrWidth-1:0] duty_q;
  logic                down_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt    <= '0;
      down_q <= 1'b0;
      per_q  <= '0;
      duty_q <= '0;
      pwm    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only: every flop here must see the pre-edge cnt/duty_q.
      pwm <= ctrl.en ? ((cnt < duty_q) ^ ctrl.pol) : ctrl.pol;
      if (!ctrl.en || sync) begin
        cnt    <= '0;
        down_q <= 1'b0;
        per_q  <= period;
        duty_q <= duty;
      end else if (restart) begin
        cnt    <= '0;
        down_q <= 1'b0;
      end else if (!ctrl.center) begin
        if (cnt >= per_q) begin
          cnt    <= '0;
          per_q  <= period;
          duty_q <= duty;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (!down_q) begin
        // A zero period never turns round, so it commits every cycle like edge mode.
        if (per_q == '0) begin
          per_q  <= period;
          duty_q <= duty;
        end else if (cnt >= per_q) begin
          down_q <= 1'b1;
          cnt    <= cnt - 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (cnt == '0) begin
        down_q <= 1'b0;
        per_q  <= period;
        duty_q <= duty;
        cnt    <= (period == '0) ? '0 : CtrWidth'(1);
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Bus-attached PWM bank: register decode, shadow/CTRL registers, SYNC fan-out and response pipeline.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int unsigned NumChannels = 12,
  parameter int unsigned CtrWidth    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   device_req_i,
  input  logic [31:0]            device_addr_i,
  input  logic                   device_we_i,
  input  logic [3:0]             device_be_i,
  input  logic [31:0]            device_wdata_i,
  output logic                   device_rvalid_o,
  output logic [31:0]            device_rdata_o,
  output logic                   device_err_o,
  output logic [NumChannels-1:0] pwm_o
);

  localparam int unsigned ChIdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  pwm_ctrl_t           ctrl_q   [NumChannels];
  logic [CtrWidth-1:0] period_q [NumChannels];
  logic [CtrWidth-1:0] duty_q   [NumChannels];
  logic [CtrWidth-1:0] cnt      [NumChannels];

  logic [6:0]             ch;
  logic [1:0]             reg_sel;
  logic [ChIdxW-1:0]      ch_idx;
  logic                   is_global, is_sync, ch_valid, acc_err, wr_ok;
  logic [31:0]            rd_val, wr_val;
  logic [NumChannels-1:0] sync_vec, restart_vec;
  logic                   unused_bits;

  assign ch        = device_addr_i[10:4];
  assign reg_sel   = device_addr_i[3:2];
  assign ch_idx    = ch[ChIdxW-1:0];
  assign is_global = device_addr_i[11];
  assign is_sync   = device_addr_i[11:2] == SYNC_OFFSET[11:2];
  assign ch_valid  = 32'(ch) < NumChannels;
  assign acc_err   = is_global ? !is_sync : (!ch_valid || (device_we_i && reg_sel == COUNT));
  assign wr_ok     = device_req_i && device_we_i && !acc_err;

  always_comb begin
    // NOTE: default assignment first so no decode path leaves rd_val unassigned (no latch).
    rd_val = '0;
    if (!is_global && ch_valid) begin
      case (reg_sel)
        CTRL:    rd_val = {29'd0, ctrl_q[ch_idx]};
        PERIOD:  rd_val = 32'(period_q[ch_idx]);
        DUTY:    rd_val = 32'(duty_q[ch_idx]);
        default: rd_val = 32'(cnt[ch_idx]);
      endcase
    end
  end

  // Byte-merge onto the addressed register's current value; SYNC reads as 0, leaving masked wdata.
  assign wr_val   = (rd_val & ~be_to_mask(device_be_i)) | (device_wdata_i & be_to_mask(device_be_i));
  assign sync_vec = (wr_ok && is_sync) ? wr_val[NumChannels-1:0] : '0;

  always_comb begin
    restart_vec = '0;
    for (int i = 0; i < NumChannels; i++) begin
      restart_vec[i] = wr_ok && !is_global && reg_sel == CTRL && ch_idx == ChIdxW'(i) &&
                       ctrl_q[i].en && (wr_val[CTRL_CENTER_BIT] != ctrl_q[i].center);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the register file is tiny and must read back 0 after reset, so every entry is reset.
      for (int i = 0; i < NumChannels; i++) begin
        ctrl_q[i]   <= '0;
        period_q[i] <= '0;
        duty_q[i]   <= '0;
      end
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
      device_err_o    <= 1'b0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_err_o    <= device_req_i && acc_err;
      device_rdata_o  <= (device_req_i && !device_we_i && !acc_err) ? rd_val : '0;
      if (wr_ok && !is_global) begin
        case (reg_sel)
          CTRL:    ctrl_q[ch_idx] <= '{center: wr_val[CTRL_CENTER_BIT],
                                       pol:    wr_val[CTRL_POL_BIT],
                                       en:     wr_val[CTRL_EN_BIT]};
          PERIOD:  period_q[ch_idx] <= wr_val[CtrWidth-1:0];
          DUTY:    duty_q[ch_idx]   <= wr_val[CtrWidth-1:0];
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NumChannels; g++) begin : g_ch
    pwm_bank_channel #(
      .CtrWidth(CtrWidth)
    ) u_channel (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .ctrl   (ctrl_q[g]),
      .period (period_q[g]),
      .duty   (duty_q[g]),
      .sync   (sync_vec[g]),
      .restart(restart_vec[g]),
      .cnt    (cnt[g]),
      .pwm    (pwm_o[g])
    );
  end

  assign unused_bits = ^{device_addr_i[31:12], device_addr_i[1:0], wr_val};

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: directed scenarios plus random bus traffic against a phase model.
module tb_pwm_bank;

  localparam int NC = 12;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          device_req_i = 1'b0;
  logic [31:0]   device_addr_i = '0;
  logic          device_we_i = 1'b0;
  logic [3:0]    device_be_i = '0;
  logic [31:0]   device_wdata_i = '0;
  logic          device_rvalid_o;
  logic [31:0]   device_rdata_o;
  logic          device_err_o;
  logic [NC-1:0] pwm_o;

  pwm_bank #(.NumChannels(NC), .CtrWidth(CW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .device_req_i   (device_req_i),
    .device_addr_i  (device_addr_i),
    .device_we_i    (device_we_i),
    .device_be_i    (device_be_i),
    .device_wdata_i (device_wdata_i),
    .device_rvalid_o(device_rvalid_o),
    .device_rdata_o (device_rdata_o),
    .device_err_o   (device_err_o),
    .pwm_o          (pwm_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each channel is a phase t inside the current period; cnt is derived
  // arithmetically from t (ramp for edge mode, triangle for centre mode).
  logic [2:0]  m_ctrl    [NC];
  int unsigned m_per_sh  [NC];
  int unsigned m_duty_sh [NC];
  int unsigned m_per     [NC];
  int unsigned m_duty    [NC];
  int unsigned m_t       [NC];
  logic [NC-1:0] exp_pwm;
  logic          exp_rvalid, exp_err;
  logic [31:0]   exp_rdata;

  function automatic int unsigned cnt_of(input int i);
    if (m_per[i] == 0) return 0;
    if (!m_ctrl[i][2]) return m_t[i];
    return (m_t[i] <= m_per[i]) ? m_t[i] : 2 * m_per[i] - m_t[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_ctrl[i] = '0; m_per_sh[i] = 0; m_duty_sh[i] = 0;
      m_per[i] = 0; m_duty[i] = 0; m_t[i] = 0;
    end
    exp_pwm = '0; exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = '0;
  endtask

  task automatic model_edge();
    logic [31:0]   a, rd, wv;
    logic          glob, is_sync, err, wr, en, pol, cen, sync_i, restart_i;
    int unsigned   ch, rg, c;
    logic [NC-1:0] npwm;
    if (rst_i) begin
      model_reset();
      return;
    end
    a       = device_addr_i;
    glob    = a[11];
    ch      = a[10:4];
    rg      = a[3:2];
    is_sync = glob && (a[10:2] == 9'd0);
    err     = glob ? !is_sync : (ch >= NC || (device_we_i && rg == 3));
    rd      = '0;
    if (!glob && ch < NC) begin
      case (rg)
        0:       rd = 32'(m_ctrl[ch]);
        1:       rd = m_per_sh[ch];
        2:       rd = m_duty_sh[ch];
        default: rd = cnt_of(ch);
      endcase
    end
    wv = rd;
    for (int b = 0; b < 4; b++) if (device_be_i[b]) wv[8*b +: 8] = device_wdata_i[8*b +: 8];
    wr = device_req_i && device_we_i && !err;
    for (int i = 0; i < NC; i++) begin
      en = m_ctrl[i][0]; pol = m_ctrl[i][1]; cen = m_ctrl[i][2];
      c = cnt_of(i);
      npwm[i]   = en ? ((c < m_duty[i]) ^ pol) : pol;
      sync_i    = wr && is_sync && wv[i];
      restart_i = wr && !glob && ch == i && rg == 0 && en && (wv[2] != cen);
      if (!en || sync_i) begin
        m_t[i] = 0; m_per[i] = m_per_sh[i]; m_duty[i] = m_duty_sh[i];
      end else if (restart_i) begin
        m_t[i] = 0;
      end else if (m_per[i] == 0 || (!cen && m_t[i] == m_per[i])) begin
        m_t[i] = 0; m_per[i] = m_per_sh[i]; m_duty[i] = m_duty_sh[i];
      end else if (cen && m_t[i] == 2 * m_per[i]) begin
        // The turning cnt==0 closes this period and opens the next, which resumes at cnt 1.
        m_t[i] = 1; m_per[i] = m_per_sh[i]; m_duty[i] = m_duty_sh[i];
      end else begin
        m_t[i]++;
      end
    end
    if (wr && !glob) begin
      case (rg)
        0:       m_ctrl[ch]    = wv[2:0];
        1:       m_per_sh[ch]  = 32'(wv[CW-1:0]);
        2:       m_duty_sh[ch] = 32'(wv[CW-1:0]);
        default: ;
      endcase
    end
    exp_pwm    = npwm;
    exp_rvalid = device_req_i;
    exp_err    = device_req_i && err;
    exp_rdata  = (device_req_i && !device_we_i && !err) ? rd : '0;
  endtask

  task automatic compare();
    check("pwm", 32'(pwm_o), 32'(exp_pwm));
    check("rvalid", 32'(device_rvalid_o), 32'(exp_rvalid));
    if (exp_rvalid) begin
      check("err", 32'(device_err_o), 32'(exp_err));
      check("rdata", device_rdata_o, exp_rdata);
    end
  endtask

  task automatic tick(input logic req, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata);
    @(negedge clk_i);
    device_req_i = req; device_we_i = we; device_addr_i = addr;
    device_be_i = be; device_wdata_i = wdata;
    @(posedge clk_i);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    tick(1'b1, 1'b1, addr, be, data);
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data, output logic err);
    tick(1'b1, 1'b0, addr, 4'hF, '0);
    data = device_rdata_o;
    err  = device_err_o;
  endtask

  function automatic logic [31:0] ch_addr(input int ch, input int rg);
    return 32'(ch * 16 + rg * 4);
  endfunction

  task automatic wait_cnt(input int ch, input int v);
    int n;
    n = 0;
    while (cnt_of(ch) != v && n < 200) begin
      idle();
      n++;
    end
    if (n >= 200) check("wait_cnt_timeout", cnt_of(ch), v);
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      idle();
      hi += int'(pwm_o[ch]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d, d2;
    logic        e;
    int          hi;
    int unsigned centre_seq [9];

    model_reset();
    rst_i = 1'b1;
    idle();
    idle();
    rst_i = 1'b0;
    check("rst_pwm", 32'(pwm_o), 32'h0);
    check("rst_rvalid", 32'(device_rvalid_o), 32'h0);
    bus_rd(ch_addr(0, 1), d, e);
    check("rst_period", d, 32'h0);
    check("rst_period_err", 32'(e), 32'h0);

    // Edge mode: period 10 cycles, 3 high.
    bus_wr(ch_addr(0, 1), 32'd9, 4'hF);
    bus_wr(ch_addr(0, 2), 32'd3, 4'hF);
    bus_wr(ch_addr(0, 0), 32'd1, 4'hF);
    wait_cnt(0, 0);
    count_high(0, 10, hi);
    check("edge_high", hi, 3);
    bus_rd(ch_addr(0, 3), d, e);
    check("edge_count_range", 32'(d <= 9), 32'h1);

    // Centre mode: triangle 0..4..0; cnt<2 is true for cnt 0 once and 1 twice per 8 cycles.
    centre_seq = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
    bus_wr(ch_addr(1, 1), 32'd4, 4'hF);
    bus_wr(ch_addr(1, 2), 32'd2, 4'hF);
    bus_wr(ch_addr(1, 0), 32'd5, 4'hF);
    for (int k = 0; k < 9; k++) begin
      bus_rd(ch_addr(1, 3), d, e);
      check("centre_seq", d, centre_seq[k]);
    end
    count_high(1, 8, hi);
    check("centre_high", hi, 3);
    bus_wr(ch_addr(1, 0), 32'd7, 4'hF);
    idle();
    count_high(1, 8, hi);
    check("centre_pol_high", hi, 5);

    // Shadow commit: mid-period DUTY write waits for the boundary.
    wait_cnt(0, 0);
    hi = 0;
    for (int k = 0; k < 4; k++) begin
      idle();
      hi += int'(pwm_o[0]);
    end
    bus_wr(ch_addr(0, 2), 32'd7, 4'hF);
    hi += int'(pwm_o[0]);
    for (int k = 0; k < 5; k++) begin
      idle();
      hi += int'(pwm_o[0]);
    end
    check("shadow_cur_period", hi, 3);
    count_high(0, 10, hi);
    check("shadow_next_period", hi, 7);
    wait_cnt(0, 9);
    bus_wr(ch_addr(0, 2), 32'd2, 4'hF);
    count_high(0, 10, hi);
    check("shadow_boundary_keep", hi, 7);
    count_high(0, 10, hi);
    check("shadow_boundary_new", hi, 2);

    // SYNC aligns ch0 and ch2.
    bus_wr(ch_addr(2, 1), 32'd9, 4'hF);
    bus_wr(ch_addr(2, 2), 32'd5, 4'hF);
    bus_wr(ch_addr(2, 0), 32'd1, 4'hF);
    repeat (3) idle();
    bus_wr(32'h800, 32'h5, 4'hF);
    bus_rd(ch_addr(0, 3), d, e);
    check("sync_ch0_zero", d, 32'h0);
    bus_rd(ch_addr(2, 3), d, e);
    check("sync_ch2_one", d, 32'h1);
    for (int k = 0; k < 5; k++) begin
      bus_rd(ch_addr(0, 3), d, e);
      bus_rd(ch_addr(2, 3), d2, e);
      check("sync_align", d2, (d + 1) % 10);
    end

    // Byte enables and field truncation.
    bus_wr(ch_addr(3, 1), 32'h1234, 4'b0010);
    bus_rd(ch_addr(3, 1), d, e);
    check("be_period", d, 32'h1200);
    bus_wr(ch_addr(3, 0), 32'hFFFF_FFF8, 4'hF);
    bus_rd(ch_addr(3, 0), d, e);
    check("ctrl_upper_ignored", d, 32'h0);
    bus_wr(ch_addr(3, 2), 32'hABCD_0005, 4'hF);
    bus_rd(ch_addr(3, 2), d, e);
    check("duty_upper_ignored", d, 32'h5);

    // Errors.
    bus_rd(ch_addr(NC, 0), d, e);
    check("err_bad_channel", 32'(e), 32'h1);
    check("err_rvalid", 32'(device_rvalid_o), 32'h1);
    idle();
    check("rvalid_single", 32'(device_rvalid_o), 32'h0);
    bus_wr(ch_addr(0, 3), 32'd5, 4'hF);
    check("err_count_write", 32'(device_err_o), 32'h1);
    bus_rd(32'h804, d, e);
    check("err_global_offset", 32'(e), 32'h1);
    bus_rd(32'h800, d, e);
    check("sync_read_err", 32'(e), 32'h0);
    check("sync_read_data", d, 32'h0);

    // Reset with a request in flight drops the response.
    rst_i = 1'b1;
    tick(1'b1, 1'b0, ch_addr(0, 1), 4'hF, '0);
    rst_i = 1'b0;
    check("rst_drop_rvalid", 32'(device_rvalid_o), 32'h0);
    check("rst_mid_pwm", 32'(pwm_o), 32'h0);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      int          r, ch, rg;
      logic [31:0] addr, data;
      logic [3:0]  be;
      r  = int'($urandom_range(0, 99));
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if (r < 40) begin
        idle();
      end else if (r < 42) begin
        rst_i = 1'b1;
        idle();
        rst_i = 1'b0;
      end else if (r < 47) begin
        bus_wr(32'h800, $urandom, be);
      end else if (r < 50) begin
        addr = 32'h800 | (32'($urandom_range(1, 511)) << 2);
        tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, be, $urandom);
      end else begin
        ch   = int'($urandom_range(0, NC + 1));
        rg   = int'($urandom_range(0, 3));
        addr = ch_addr(ch, rg) | ($urandom & 32'hFFFF_F000);
        case (rg)
          0:       data = 32'($urandom_range(0, 7)) | ($urandom & 32'hFFFF_FFF8);
          1:       data = 32'($urandom_range(0, 12)) | ($urandom & 32'hFFFF_0000);
          default: data = 32'($urandom_range(0, 14)) | ($urandom & 32'hFFFF_0000);
        endcase
        tick(1'b1, 1'($urandom_range(0, 1)), addr, be, data);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
